wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: number of buffered multiply/divide (MDU) results.
REQ-002 Parameter STARVE_LIMIT, default 4: maximum consecutive ALU grants while MDU results wait.
REQ-003 clk  input  1: single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1: asynchronous, active-low reset.
REQ-005 alu_valid  input  1: ALU pipe presents a result.
REQ-006 alu_ready  output  1: arbiter accepts the ALU result this cycle.
REQ-007 alu_rw_addr  input  5: ALU destination register.
REQ-008 alu_rw_data  input  32: ALU result.
REQ-009 mdu_valid  input  1: MDU presents a result.
REQ-010 mdu_ready  output  1: FIFO has room for the MDU result.
REQ-011 mdu_rw_addr  input  5: MDU destination register.
REQ-012 mdu_rw_data  input  32: MDU result.
REQ-013 chk_rs_addr, chk_rt_addr  input  5 each: decoder source registers to check.
REQ-014 chk_rs_pending, chk_rt_pending  output  1 each: a write to that register is still in flight.
REQ-015 wb_uses_rw  output  1: register-file write enable.
REQ-016 wb_rw_addr  output  5: register-file write address.
REQ-017 wb_rw_data  output  32: register-file write data.

Function
REQ-018 The ALU handshake completes on alu_valid & alu_ready, and the MDU handshake on mdu_valid & mdu_ready.
REQ-019 mdu_ready SHALL be (count < FIFO_DEPTH), computed from the registered count only, with no pop-through when full.
REQ-020 An accepted MDU result with addr != 0 SHALL be enqueued at the tail; one with addr 0 SHALL be accepted and discarded.
REQ-021 Per-cycle grant: ALU handshake wins; otherwise pop the FIFO head if count > 0; otherwise no grant.
REQ-022 wb_* are registered: a grant at edge N drives wb_uses_rw/addr/data from edge N to edge N+1 (1-cycle latency).
REQ-023 With no grant, wb_uses_rw SHALL be 0 and wb_rw_addr/wb_rw_data SHALL hold their previous values.
REQ-024 A granted entry with addr 0 SHALL drive wb_uses_rw = 0.
REQ-025 An entry enqueued at edge N is not poppable before edge N+1, so MDU minimum latency is 2 cycles.
REQ-026 Simultaneous enqueue and pop leave count unchanged, and the FIFO preserves MDU order.
REQ-027 starve_cnt increments on each ALU grant while count > 0, and clears on any FIFO pop or when count == 0.
REQ-028 alu_ready SHALL be (starve_cnt < STARVE_LIMIT); when it is 0 the FIFO pops and starve_cnt clears.
REQ-029 chk_*_pending SHALL be 1 iff the address is != 0 and matches either a valid FIFO entry or the wb output while wb_uses_rw = 1.
REQ-030 chk_*_pending is combinational from registered state.
REQ-031 The arbiter does not prevent an ALU write from overtaking a buffered MDU write to the same register; upstream stalls on chk_*_pending.

Reset
REQ-032 While rst_n = 0: wb_uses_rw = 0, wb_rw_addr = 0, wb_rw_data = 0, count = 0, starve_cnt = 0, alu_ready = 1, mdu_ready = 1, and both pending outputs = 0.
REQ-033 Reset asserted mid-operation SHALL discard all buffered entries immediately, and no write SHALL be issued for them after release.

Verification
REQ-034 ALU only: alu_valid = 1, addr 5, data 0x1234 at edge N -> wb_uses_rw = 1, addr 5, data 0x1234 for the cycle after N; 0 after if idle.
REQ-035 MDU fill: 5 back-to-back MDU results to addrs 1-5 with ALU idle -> popped 1, 2, 3, ... in order starting edge 2; mdu_ready never drops.
REQ-036 MDU fill with ALU valid every cycle -> after 4 MDU accepts mdu_ready = 0; every 5th cycle alu_ready = 0 and one MDU entry drains, and no ALU result is lost.
REQ-037 Zero register: ALU addr 0 data 0xFFFF -> wb_uses_rw stays 0; MDU addr 0 -> not enqueued, count unchanged, pending 0.
REQ-038 Pending: MDU addr 7 enqueued with ALU busy; chk_rs_addr = 7 -> chk_rs_pending = 1 until the wb cycle for reg 7 ends, then 0.
REQ-039 Reset mid-flight: 3 entries buffered, pulse rst_n low for 1 cycle -> count = 0, wb_uses_rw = 0, and no stale write appears afterwards.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// Bundle of the ALU/MDU result handshakes, hazard-check ports and register-file write port
// used by the write-back arbiter.
interface wb_arbiter_if;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;

    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_rw_addr;
    logic [DATA_W-1:0] alu_rw_data;
    logic              mdu_valid;
    logic              mdu_ready;
    logic [ADDR_W-1:0] mdu_rw_addr;
    logic [DATA_W-1:0] mdu_rw_data;
    logic [ADDR_W-1:0] chk_rs_addr;
    logic [ADDR_W-1:0] chk_rt_addr;
    logic              chk_rs_pending;
    logic              chk_rt_pending;
    logic              wb_uses_rw;
    logic [ADDR_W-1:0] wb_rw_addr;
    logic [DATA_W-1:0] wb_rw_data;

    modport slave (
        input  alu_valid, alu_rw_addr, alu_rw_data,
        input  mdu_valid, mdu_rw_addr, mdu_rw_data,
        input  chk_rs_addr, chk_rt_addr,
        output alu_ready, mdu_ready,
        output chk_rs_pending, chk_rt_pending,
        output wb_uses_rw, wb_rw_addr, wb_rw_data
    );

    modport master (
        output alu_valid, alu_rw_addr, alu_rw_data,
        output mdu_valid, mdu_rw_addr, mdu_rw_data,
        output chk_rs_addr, chk_rt_addr,
        input  alu_ready, mdu_ready,
        input  chk_rs_pending, chk_rt_pending,
        input  wb_uses_rw, wb_rw_addr, wb_rw_data
    );
endinterface

// File: rtl/wb_arbiter.sv
// Write-back arbiter: ALU results go straight to the register file, MDU results are buffered
// in a small FIFO and drained when the ALU is idle or has starved the FIFO too long.
module wb_arbiter #(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic         clk,
    input logic         rst_n,
    wb_arbiter_if.slave bus
);
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned STV_W  = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t              mem [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] slot_vld;
    logic [PTR_W-1:0]    head;
    logic [PTR_W-1:0]    tail;
    logic [CNT_W-1:0]    count;
    logic [STV_W-1:0]    starve_cnt;
    logic                wb_uses_q;
    logic [ADDR_W-1:0]   wb_addr_q;
    logic [DATA_W-1:0]   wb_data_q;

    logic   alu_ready_c;
    logic   mdu_ready_c;
    logic   alu_fire;
    logic   push;
    logic   pop;
    entry_t head_ent;
    logic   rs_hit;
    logic   rt_hit;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign alu_ready_c = (starve_cnt < STV_W'(STARVE_LIMIT));
    assign mdu_ready_c = (count < CNT_W'(FIFO_DEPTH));
    assign alu_fire    = bus.alu_valid & alu_ready_c;
    assign push        = bus.mdu_valid & mdu_ready_c & (bus.mdu_rw_addr != '0);
    assign pop         = ~alu_fire & (count != '0);
    assign head_ent    = mem[head];

    assign bus.alu_ready  = alu_ready_c;
    assign bus.mdu_ready  = mdu_ready_c;
    assign bus.wb_uses_rw = wb_uses_q;
    assign bus.wb_rw_addr = wb_addr_q;
    assign bus.wb_rw_data = wb_data_q;

    // Hazard lookup over every live FIFO slot plus the write currently on the port.
    always_comb begin
        rs_hit = wb_uses_q && (wb_addr_q == bus.chk_rs_addr);
        rt_hit = wb_uses_q && (wb_addr_q == bus.chk_rt_addr);
        for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            if (slot_vld[i] && (mem[i].addr == bus.chk_rs_addr)) rs_hit = 1'b1;
            if (slot_vld[i] && (mem[i].addr == bus.chk_rt_addr)) rt_hit = 1'b1;
        end
    end

    assign bus.chk_rs_pending = (bus.chk_rs_addr != '0) & rs_hit;
    assign bus.chk_rt_pending = (bus.chk_rt_addr != '0) & rt_hit;

    always_ff @(posedge clk) begin
        if (push) mem[tail] <= entry_t'({bus.mdu_rw_addr, bus.mdu_rw_data});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            slot_vld   <= '0;
            starve_cnt <= '0;
            wb_uses_q  <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
        end else begin
            if (push) begin
                slot_vld[tail] <= 1'b1;
                tail           <= ptr_inc(tail);
            end
            if (pop) begin
                slot_vld[head] <= 1'b0;
                head           <= ptr_inc(head);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);

            // Starvation only accrues while MDU results are actually waiting.
            if (pop || (count == '0)) starve_cnt <= '0;
            else if (alu_fire)        starve_cnt <= starve_cnt + STV_W'(1);

            if (alu_fire) begin
                wb_uses_q <= (bus.alu_rw_addr != '0);
                wb_addr_q <= bus.alu_rw_addr;
                wb_data_q <= bus.alu_rw_data;
            end else if (pop) begin
                wb_uses_q <= (head_ent.addr != '0);
                wb_addr_q <= head_ent.addr;
                wb_data_q <= head_ent.data;
            end else begin
                wb_uses_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: vector table, directed corner sequences and a random
// run, all checked against a scoreboard fed by a behavioural model.
module tb_wb_arbiter;
    localparam int unsigned FIFO_DEPTH   = 4;
    localparam int unsigned STARVE_LIMIT = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    wb_arbiter_if bus();

    wb_arbiter #(.FIFO_DEPTH(FIFO_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } ent_t;

    typedef struct {
        logic        uses;
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_t;

    typedef struct {
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  ma;
        logic [31:0] md;
        logic        eu;
        logic [4:0]  ea;
        logic [31:0] ed;
    } vec_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    ent_t mq[$];
    wb_t  sbq[$];
    int   m_starve;
    wb_t  m_wb;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_pending(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        if (m_wb.uses && (m_wb.addr == a)) return 1'b1;
        foreach (mq[i]) if (mq[i].addr == a) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        mq.delete();
        sbq.delete();
        m_starve = 0;
        m_wb     = '{1'b0, 5'd0, 32'd0};
    endtask

    // One clock: drive, check pre-edge outputs, predict the grant, then check wb after the edge.
    task automatic step(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                        input logic mv, input logic [4:0] ma, input logic [31:0] md,
                        input logic [4:0] rs, input logic [4:0] rt,
                        output logic ar, output logic mr, output logic pr);
        wb_t  e;
        ent_t h;
        logic a_rdy, m_rdy, afire, mfire;
        bus.alu_valid   = av;
        bus.alu_rw_addr = aa;
        bus.alu_rw_data = ad;
        bus.mdu_valid   = mv;
        bus.mdu_rw_addr = ma;
        bus.mdu_rw_data = md;
        bus.chk_rs_addr = rs;
        bus.chk_rt_addr = rt;
        #1;
        a_rdy = (m_starve < int'(STARVE_LIMIT));
        m_rdy = (mq.size() < int'(FIFO_DEPTH));
        check("alu_ready", 32'(bus.alu_ready), 32'(a_rdy));
        check("mdu_ready", 32'(bus.mdu_ready), 32'(m_rdy));
        check("rs_pending", 32'(bus.chk_rs_pending), 32'(m_pending(rs)));
        check("rt_pending", 32'(bus.chk_rt_pending), 32'(m_pending(rt)));
        ar = bus.alu_ready;
        mr = bus.mdu_ready;
        pr = bus.chk_rs_pending;
        afire = av && a_rdy;
        mfire = mv && m_rdy;
        if (afire) begin
            e = '{aa != 5'd0, aa, ad};
            m_starve = (mq.size() > 0) ? m_starve + 1 : 0;
        end else if (mq.size() > 0) begin
            h = mq.pop_front();
            e = '{1'b1, h.addr, h.data};
            m_starve = 0;
        end else begin
            e = '{1'b0, m_wb.addr, m_wb.data};
            m_starve = 0;
        end
        if (mfire && (ma != 5'd0)) mq.push_back('{ma, md});
        m_wb = e;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        check("wb_uses_rw", 32'(bus.wb_uses_rw), 32'(e.uses));
        check("wb_rw_addr", 32'(bus.wb_rw_addr), 32'(e.addr));
        check("wb_rw_data", bus.wb_rw_data, e.data);
    endtask

    task automatic idle(input int n, input logic [4:0] rs, input logic [4:0] rt);
        logic ar, mr, pr;
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, rs, rt, ar, mr, pr);
    endtask

    vec_t tbl[11];

    initial begin
        logic ar, mr, pr;
        int   stalls;

        tbl[0]  = '{1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0,   1'b1, 5'd5, 32'h1234};
        tbl[1]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,   1'b0, 5'd5, 32'h1234};
        tbl[2]  = '{1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'h0,   1'b0, 5'd0, 32'hFFFF};
        tbl[3]  = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd0, 32'hAAAA, 1'b0, 5'd0, 32'hFFFF};
        tbl[4]  = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd1, 32'h101, 1'b0, 5'd0, 32'hFFFF};
        tbl[5]  = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd2, 32'h102, 1'b1, 5'd1, 32'h101};
        tbl[6]  = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd3, 32'h103, 1'b1, 5'd2, 32'h102};
        tbl[7]  = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd4, 32'h104, 1'b1, 5'd3, 32'h103};
        tbl[8]  = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd5, 32'h105, 1'b1, 5'd4, 32'h104};
        tbl[9]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,   1'b1, 5'd5, 32'h105};
        tbl[10] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,   1'b0, 5'd5, 32'h105};

        rst_n           = 1'b0;
        bus.alu_valid   = 1'b0;
        bus.alu_rw_addr = '0;
        bus.alu_rw_data = '0;
        bus.mdu_valid   = 1'b0;
        bus.mdu_rw_addr = '0;
        bus.mdu_rw_data = '0;
        bus.chk_rs_addr = 5'd5;
        bus.chk_rt_addr = 5'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_wb_uses", 32'(bus.wb_uses_rw), 32'd0);
        check("rst_wb_addr", 32'(bus.wb_rw_addr), 32'd0);
        check("rst_wb_data", bus.wb_rw_data, 32'd0);
        check("rst_alu_ready", 32'(bus.alu_ready), 32'd1);
        check("rst_mdu_ready", 32'(bus.mdu_ready), 32'd1);
        check("rst_rs_pending", 32'(bus.chk_rs_pending), 32'd0);
        rst_n = 1'b1;

        // Vector table: ALU path, zero register, MDU fill/drain order.
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].av, tbl[i].aa, tbl[i].ad, tbl[i].mv, tbl[i].ma, tbl[i].md,
                 5'd5, 5'd1, ar, mr, pr);
            check($sformatf("tbl%0d_uses", i), 32'(bus.wb_uses_rw), 32'(tbl[i].eu));
            check($sformatf("tbl%0d_addr", i), 32'(bus.wb_rw_addr), 32'(tbl[i].ea));
            check($sformatf("tbl%0d_data", i), bus.wb_rw_data, tbl[i].ed);
            if (i >= 4 && i <= 8) check($sformatf("tbl%0d_mdu_ready", i), 32'(mr), 32'd1);
        end

        // ALU and MDU both valid every cycle: FIFO fills, ALU stalls every 5th cycle.
        stalls = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 5'(8 + i % 8), 32'h1000 + 32'(i), 1'b1, 5'(1 + i % 7), 32'h2000 + 32'(i),
                 5'd3, 5'd9, ar, mr, pr);
            if (!ar) stalls++;
            if (i == 4) check("starve_mdu_full", 32'(mr), 32'd0);
            if (i == 5) check("starve_alu_stall", 32'(ar), 32'd0);
        end
        check("starve_stall_count", 32'(stalls), 32'd3);
        idle(8, 5'd0, 5'd0);

        // Pending on reg 7 while the ALU keeps the port busy.
        for (int k = 0; k < 9; k++) begin
            step(1'b1, 5'd20, 32'h3000 + 32'(k), (k == 0), 5'd7, 32'h777, 5'd7, 5'd9, ar, mr, pr);
            if (k == 1) check("pend_buffered", 32'(pr), 32'd1);
            if (k == 5) check("pend_alu_stall", 32'(ar), 32'd0);
            if (k == 6) check("pend_on_wb", 32'(pr), 32'd1);
            if (k == 7) check("pend_cleared", 32'(pr), 32'd0);
        end
        idle(3, 5'd0, 5'd0);

        // Reset with three entries buffered.
        for (int k = 0; k < 3; k++)
            step(1'b1, 5'd11, 32'h4000 + 32'(k), 1'b1, 5'(1 + k), 32'h5000 + 32'(k),
                 5'd1, 5'd2, ar, mr, pr);
        rst_n         = 1'b0;
        bus.alu_valid = 1'b0;
        bus.mdu_valid = 1'b0;
        #2;
        check("midrst_wb_uses", 32'(bus.wb_uses_rw), 32'd0);
        check("midrst_wb_addr", 32'(bus.wb_rw_addr), 32'd0);
        check("midrst_wb_data", bus.wb_rw_data, 32'd0);
        check("midrst_mdu_ready", 32'(bus.mdu_ready), 32'd1);
        check("midrst_alu_ready", 32'(bus.alu_ready), 32'd1);
        check("midrst_rs_pending", 32'(bus.chk_rs_pending), 32'd0);
        check("midrst_rt_pending", 32'(bus.chk_rt_pending), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        idle(6, 5'd1, 5'd2);

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 9) < 7), 5'($urandom_range(0, 7)), $urandom,
                 ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), ar, mr, pr);
        end
        idle(8, 5'd0, 5'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
